// File: rtl/bcd_pkg.sv
// Shared types, widths and the one-hot to BCD encoder for the key encoder.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned KEY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    // Returns {is_onehot, bcd}; key n maps to digit n (inverse of the decoder table).
    function automatic logic [BCD_W:0] onehot_to_bcd(input logic [KEY_W-1:0] v);
        logic [BCD_W-1:0] bcd;
        logic             oh;
        bcd = '0;
        oh  = (v != '0) && ((v & (v - KEY_W'(1))) == '0);
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (v[i]) bcd = BCD_W'(i);
        end
        return {oh, bcd};
    endfunction

endpackage

// File: rtl/bcd_fifo.sv
// First-word fall-through synchronous FIFO for encoded digits.
module bcd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign rd_ok   = rd_en && !empty;
    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bcd_key_enc.sv
// Debounced decimal keypad encoder with a digit queue and sticky error flags.
module bcd_key_enc
    import bcd_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KEY_W-1:0]              key,
    output logic [BCD_W-1:0]              out,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          err,
    output logic                          ovf,
    input  logic                          err_clr
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [KEY_W-1:0]  s1, s2;
    logic [KEY_W-1:0]  snap, snap_nx;
    logic [BCD_W:0]    enc;
    logic              err_set, ovf_set, err_nx, ovf_nx;
    logic              push, pop, full, empty;

    assign enc   = onehot_to_bcd(snap);
    assign pop   = valid && ready;
    assign valid = !empty;

    // Two-flop synchronizer, FSM state and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            state <= ST_IDLE;
            cnt   <= '0;
            snap  <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            s1    <= key;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            snap  <= snap_nx;
            err   <= err_nx;
            ovf   <= ovf_nx;
        end
    end

    // Debounce / emit / release-wait sequencing.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        snap_nx  = snap;
        err_set  = 1'b0;
        ovf_set  = 1'b0;
        push     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s2 != '0) begin
                    snap_nx  = s2;
                    cnt_nx   = '0;
                    state_nx = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (s2 == '0) begin
                    state_nx = ST_IDLE;
                end else if (s2 != snap) begin
                    snap_nx = s2;
                    cnt_nx  = '0;
                end else if (cnt == CNT_LAST) begin
                    if (enc[BCD_W]) begin
                        state_nx = ST_EMIT;
                    end else begin
                        err_set  = 1'b1;
                        state_nx = ST_WAIT_REL;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                push     = !full || pop;
                ovf_set  = !push;
                cnt_nx   = '0;
                state_nx = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (s2 != '0) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Setting a flag takes priority over a same-cycle clear.
        err_nx = err_set || (err && !err_clr);
        ovf_nx = ovf_set || (ovf && !err_clr);
    end

    bcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BCD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (enc[BCD_W-1:0]),
        .rd_en   (pop),
        .rd_data (out),
        .full    (full),
        .empty   (empty),
        .cnt     (fifo_cnt)
    );

endmodule

// File: tb/tb_bcd_key_enc.sv
// Scoreboard bench for bcd_key_enc: stimulus queues expected digits, monitor checks pops.
module tb_bcd_key_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] key;
    logic [3:0] out;
    logic       valid;
    logic       ready;
    logic [2:0] fifo_cnt;
    logic       err;
    logic       ovf;
    logic       err_clr;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb [$];

    bcd_key_enc #(.DEB_CYC(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .out      (out),
        .valid    (valid),
        .ready    (ready),
        .fifo_cnt (fifo_cnt),
        .err      (err),
        .ovf      (ovf),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Press one key for 'hold' cycles then release long enough to rearm.
    task automatic press(input int d, input int hold);
        logic [9:0] k;
        k   = 10'd1 << d;
        key = k;
        tick(hold);
        key = '0;
        tick(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out"}, int'(out), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_cnt"}, int'(fifo_cnt), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
    endtask

    // Monitor: every accepted handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0d expected none", out);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0d expected %0d", out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; key = '0; ready = 1'b0; err_clr = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Single press: 7-cycle latency, one digit only.
        key = 10'h008;
        tick(7);
        chk("latency_early_valid", int'(valid), 0);
        tick(1);
        chk("single_valid", int'(valid), 1);
        chk("single_out", int'(out), 3);
        sb.push_back(4'd3);
        tick(12);
        chk("single_hold_cnt", int'(fifo_cnt), 1);
        key = '0;
        tick(10);

        // Bounce: short pulses never reach the debounce threshold.
        for (int i = 0; i < 5; i++) begin
            key = (i % 2 == 0) ? 10'h020 : 10'h000;
            tick(2);
        end
        chk("bounce_no_push", int'(fifo_cnt), 1);
        key = 10'h020;
        tick(12);
        chk("bounce_push", int'(fifo_cnt), 2);
        sb.push_back(4'd5);
        key = '0;
        tick(10);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        chk("drain1_valid", int'(valid), 0);
        chk("drain1_out", int'(out), 0);

        // Multi-hot press flags ERR, no digit; clear next cycle.
        key = 10'h081;
        tick(10);
        chk("multi_err", int'(err), 1);
        chk("multi_cnt", int'(fifo_cnt), 0);
        key = '0;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("multi_err_clr", int'(err), 0);
        tick(10);

        // Overflow: fifth digit dropped.
        for (int d = 1; d <= 5; d++) begin
            press(d, 10);
            if (d <= 4) sb.push_back(4'(d));
        end
        chk("ovf_cnt", int'(fifo_cnt), 4);
        chk("ovf_flag", int'(ovf), 1);

        // Full FIFO with pop in the EMIT cycle accepts the new digit.
        key = 10'h040;
        tick(7);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        sb.push_back(4'd6);
        chk("fullpop_cnt", int'(fifo_cnt), 4);
        chk("fullpop_ovf", int'(ovf), 1);
        key = '0;
        tick(10);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);
        ready = 1'b1;
        tick(5);
        ready = 1'b0;
        chk("drain2_valid", int'(valid), 0);

        // Handshake: back-to-back pops of 7 then 9.
        press(7, 10);
        press(9, 10);
        sb.push_back(4'd7);
        sb.push_back(4'd9);
        chk("hs_cnt", int'(fifo_cnt), 2);
        ready = 1'b1;
        tick(1);
        chk("hs_second_out", int'(out), 9);
        tick(1);
        ready = 1'b0;
        chk("hs_empty_valid", int'(valid), 0);
        chk("hs_empty_out", int'(out), 0);

        // Reset mid-debounce with two digits queued.
        press(1, 10);
        press(2, 10);
        chk("pre_rst_cnt", int'(fifo_cnt), 2);
        key = 10'h200;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        tick(2);
        #3;
        rst_n = 1'b1;
        tick(12);
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_out", int'(out), 9);
        chk("post_rst_cnt", int'(fifo_cnt), 1);
        sb.push_back(4'd9);
        key = '0;
        tick(10);
        ready = 1'b1;
        tick(2);
        ready = 1'b0;
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_key_enc.md
Name: bcd_key_enc

Overview:
Encoder counterpart of the BCD one-hot decoder. Takes 10 asynchronous decimal-key lines (one-hot: key n drives bit n). It synchronizes and debounces them, then encodes a stable single key to a 4-bit BCD digit. Digits are queued in a small FIFO and delivered through a VALID/READY handshake. Multi-key presses flag ERR; digits dropped because the FIFO is full flag OVF.

Parameters:
DEB_CYC, 4, consecutive stable cycles required to accept a press or a release (range 2..255).
FIFO_DEPTH, 4, digit queue depth (power of 2, at least 2).

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  reset, asynchronous assert, active-low.
KEY  in  10  raw key lines, asynchronous to CLK.
OUT  out  4  BCD digit at FIFO head; 4'h0 when the FIFO is empty.
VALID  out  1  FIFO non-empty.
READY  in  1  consumer accepts OUT on a rising edge where VALID && READY.
FIFO_CNT  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
ERR  out  1  sticky: a stable multi-hot KEY pattern was seen.
OVF  out  1  sticky: a digit was dropped because the FIFO was full.
ERR_CLR  in  1  synchronous clear of ERR and OVF.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset is asynchronous and active-low, on RST_N.
  - While RST_N=0: synchronizer flops, snapshot, counter, FIFO pointers and count are all 0; state=IDLE.
  - Outputs while RST_N=0: OUT=0, VALID=0, FIFO_CNT=0, ERR=0, OVF=0.
  - Reset mid-debounce or mid-queue discards all pending data. After release, a still-held key is treated as a new press.
- Synchronizer: KEY passes through two flops, S1 then S2. All logic uses S2 only.
- FSM states: IDLE, DEBOUNCE, EMIT, WAIT_REL. Counter cnt is 8 bits wide.
- IDLE:
  - If S2 != 0: capture snap <= S2, set cnt <= 0, go to DEBOUNCE.
- DEBOUNCE:
  - If S2 == 0: go to IDLE.
  - Else if S2 != snap: snap <= S2, cnt <= 0, stay (restart).
  - Else if cnt == DEB_CYC-1: if snap is one-hot, go to EMIT; otherwise set ERR and go to WAIT_REL.
  - Otherwise cnt <= cnt+1.
- EMIT (exactly one cycle):
  - Push the BCD code of snap (bit n gives n) if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise set OVF and drop the digit.
  - Go to WAIT_REL with cnt <= 0.
- WAIT_REL:
  - If S2 != 0: cnt <= 0.
  - Otherwise, when cnt == DEB_CYC-1, go to IDLE; otherwise cnt <= cnt+1.
  - A held key therefore produces exactly one digit.
- Latency: let KEY be first captured by S1 at edge k.
  - DEBOUNCE is entered at k+2 and EMIT at k+2+DEB_CYC.
  - VALID rises after edge k+3+DEB_CYC, i.e. 7 cycles after capture for DEB_CYC=4, with an empty FIFO.
- FIFO:
  - Synchronous, first-word fall-through: OUT and VALID reflect the head combinationally from registers.
  - Pop on VALID && READY. READY while empty is ignored.
  - Simultaneous push and pop leaves FIFO_CNT unchanged. Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: ERR_CLR=1 clears ERR and OVF on the next edge. If a set and ERR_CLR occur in the same cycle, the set wins.

Decomposition:
- Shared package bcd_pkg:
  - State encoding localparams ST_IDLE/ST_DEBOUNCE/ST_EMIT/ST_WAIT_REL.
  - Function onehot_to_bcd, returning {is_onehot, bcd[3:0]}. It is the exact inverse of the decoder's code table.
  - Constant BCD_W=4.
- One sub-module: bcd_fifo (parameterized sync FIFO with wr_en/rd_en/full/empty/cnt). The FSM and synchronizer stay in bcd_key_enc.

Test Plan:
- Single press: KEY=10'h008 held 20 cycles with DEB_CYC=4, READY=0 → after the 7-cycle latency VALID=1, OUT=4'h3, FIFO_CNT=1. Exactly one digit is queued, with none on repeat.
- Bounce: KEY toggles 10'h020/0 every 2 cycles for 10 cycles, then holds 10'h020 → no push during the bounce; exactly one OUT=4'h5 after DEB_CYC stable cycles.
- Multi-hot: KEY=10'h081 held 10 cycles → ERR=1, FIFO_CNT=0. ERR_CLR pulse → ERR=0 the next cycle.
- Overflow: READY=0, press digits 1,2,3,4,5 with releases between → FIFO_CNT=4, OVF=1, and the outputs drain as 1,2,3,4. Then press 6 with READY=1 held on a full FIFO → push accepted, OVF unchanged.
- Handshake: queue 7 and 9, then READY=1 for 2 cycles → OUT=7 then 9 on consecutive edges, then VALID=0, OUT=0.
- Reset mid-operation: assert RST_N=0 asynchronously during DEBOUNCE with 2 digits queued → all outputs 0 immediately. Held KEY=10'h200 after release → a fresh debounce, then OUT=4'h9.
